// File: rtl/rgb_pwm_led_ctrl.sv
// rgb_pwm_led_ctrl: multi-channel PWM LED driver. Each channel has its own brightness
// and an OFF/SOLID/BLINK/BREATHE mode. Configuration arrives through a single-entry
// valid/ready slot and commits only at a PWM period boundary, so the pins never glitch.
module rgb_pwm_led_ctrl #(
  parameter int NUM_CH        = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 64,
  parameter int BLINK_PERIODS = 128,
  parameter int BREATHE_DIV   = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic                period_pulse,
  output logic [NUM_CH-1:0]   led_out
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int BRD_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [BLK_W-1:0]    BLK_ONE  = BLK_W'(1);
  localparam logic [BRD_W-1:0]    BRD_LAST = BRD_W'(BREATHE_DIV - 1);
  localparam logic [BRD_W-1:0]    BRD_ONE  = BRD_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [CH_W:0]       NUM_CH_V = (CH_W + 1)'(NUM_CH);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_SOLID   = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  // timebase
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_tick;
  logic                w_pend;

  // config slot
  logic                r_slot_full;
  logic                w_slot_full_next;
  logic [CH_W-1:0]     r_slot_ch;
  logic [1:0]          r_slot_mode;
  logic [PWM_BITS-1:0] r_slot_duty;
  logic                r_cfg_ready;
  logic                r_cfg_err;
  logic                r_period_pulse;
  logic                w_accept;
  logic                w_commit;
  logic                w_ch_ok;

  // shared blink / breathe timing
  logic [BLK_W-1:0]    r_blink_cnt;
  logic                r_blink_phase;
  logic [BRD_W-1:0]    r_br_cnt;
  logic                w_br_step;

  // per-channel effective duty and registered pin drive
  logic [PWM_BITS-1:0] w_eff [NUM_CH];
  logic [NUM_CH-1:0]   r_led;

  assign w_tick   = (r_pre_cnt == PRE_LAST);
  assign w_pend   = w_tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_accept = cfg_valid && r_cfg_ready;
  // The slot is only ever full while ready is low, so an accept in the pend cycle
  // cannot collide with a commit; it simply waits for the next boundary.
  assign w_commit = w_pend && r_slot_full;
  assign w_ch_ok  = ({1'b0, r_slot_ch} < NUM_CH_V);
  assign w_br_step = w_pend && (r_br_cnt == BRD_LAST);

  assign cfg_ready    = r_cfg_ready;
  assign cfg_err      = r_cfg_err;
  assign period_pulse = r_period_pulse;
  assign led_out      = r_led;

  // Prescaler and PWM counter; the PWM counter wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      if (w_tick) begin
        r_pre_cnt <= '0;
        r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      end else begin
        r_pre_cnt <= r_pre_cnt + PRE_ONE;
      end
    end
  end

  // Slot occupancy: filled on accept, emptied by a commit at the period boundary.
  always_comb begin
    w_slot_full_next = r_slot_full;
    if (w_commit) w_slot_full_next = 1'b0;
    if (w_accept) w_slot_full_next = 1'b1;
  end

  // Handshake registers, error pulse and period pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_full    <= 1'b0;
      r_slot_ch      <= '0;
      r_slot_mode    <= MODE_OFF;
      r_slot_duty    <= '0;
      r_cfg_ready    <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_period_pulse <= 1'b0;
    end else begin
      r_slot_full    <= w_slot_full_next;
      r_cfg_ready    <= !w_slot_full_next;
      r_cfg_err      <= w_commit && !w_ch_ok;
      r_period_pulse <= w_pend;
      if (w_accept) begin
        r_slot_ch   <= cfg_ch;
        r_slot_mode <= cfg_mode;
        r_slot_duty <= cfg_duty;
      end
    end
  end

  // Shared blink phase and breathe step divider, both advancing once per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_br_cnt      <= '0;
    end else if (w_pend) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_ONE;
      end
      if (r_br_cnt == BRD_LAST) r_br_cnt <= '0;
      else                      r_br_cnt <= r_br_cnt + BRD_ONE;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]          r_mode;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_level;
    logic                r_down;
    logic                w_sel;

    assign w_sel = w_commit && w_ch_ok && (r_slot_ch == CH_W'(gi));

    // Channel config and triangle breathe level; a commit overrides a step in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= MODE_OFF;
        r_duty  <= '0;
        r_level <= '0;
        r_down  <= 1'b0;
      end else if (w_sel) begin
        r_mode <= r_slot_mode;
        r_duty <= r_slot_duty;
        if (r_slot_mode == MODE_BREATHE) begin
          r_level <= '0;
          r_down  <= 1'b0;
        end else if (r_slot_duty < r_level) begin
          r_level <= r_slot_duty;
          r_down  <= 1'b1;
        end
      end else if (w_br_step && (r_mode == MODE_BREATHE)) begin
        if (!r_down) begin
          if (r_level < r_duty) begin
            r_level <= r_level + PWM_ONE;
          end else if (r_level != '0) begin
            r_level <= r_level - PWM_ONE;
            r_down  <= 1'b1;
          end
        end else begin
          if (r_level != '0) begin
            r_level <= r_level - PWM_ONE;
          end else if (r_duty != '0) begin
            r_level <= r_level + PWM_ONE;
            r_down  <= 1'b0;
          end
        end
      end
    end

    assign w_eff[gi] = (r_mode == MODE_SOLID)                    ? r_duty  :
                       ((r_mode == MODE_BLINK) && r_blink_phase) ? r_duty  :
                       (r_mode == MODE_BREATHE)                  ? r_level :
                                                                   '0;
  end

  // Registered PWM compare per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_led[i] <= (r_pwm_cnt < w_eff[i]);
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_led_ctrl.sv
// tb_rgb_pwm_led_ctrl: directed bench for the PWM LED controller with a 16-tick period,
// prescale 1, two-period blink half-phase and one-period breathe steps.
module tb_rgb_pwm_led_ctrl;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_SOLID   = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_duty = 4'd0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       period_pulse;
  logic [2:0] led_out;

  int checks = 0;
  int failures = 0;
  int m_cyc;  // clock edges since the last reset release

  rgb_pwm_led_ctrl #(
    .NUM_CH(3), .PWM_BITS(4), .PRESCALE(1), .BLINK_PERIODS(2), .BREATHE_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
    .period_pulse(period_pulse), .led_out(led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= 0;
    else        m_cyc <= m_cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count high samples per channel over one full 16-tick window, plus any error pulses.
  task automatic measure(output int c0, output int c1, output int c2, output int errs);
    c0 = 0; c1 = 0; c2 = 0; errs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c0 += int'(led_out[0]);
      c1 += int'(led_out[1]);
      c2 += int'(led_out[2]);
      errs += int'(cfg_err);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    int n = 0;
    while (!cfg_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_ready_wait: cfg_ready=%b required 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_duty = duty;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_ready_fall: cfg_ready=%b required 0", cfg_ready);
    end
    $display("write ch=%0d mode=%0d duty=%0d accepted at cyc=%0d", ch, mode, duty, m_cyc);
  endtask

  // Wait for cfg_ready to return; that edge must be a period boundary with period_pulse high.
  task automatic wait_commit(input string name);
    int n = 0;
    while (!cfg_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1 || (m_cyc % 16) != 0 || period_pulse !== 1'b1) begin
      failures++;
      $display("FAIL %s_commit: ready=%b cyc_mod16=%0d pulse=%b required ready=1 cyc_mod16=0 pulse=1",
               name, cfg_ready, m_cyc % 16, period_pulse);
    end
  endtask

  task automatic check_period(input string name, input int e0, input int e1, input int e2);
    int c0, c1, c2, errs;
    measure(c0, c1, c2, errs);
    checks++;
    if (c0 !== e0 || c1 !== e1 || c2 !== e2 || errs !== 0 || period_pulse !== 1'b1) begin
      failures++;
      $display("FAIL %s: on-counts %0d/%0d/%0d err=%0d pulse=%b required %0d/%0d/%0d err=0 pulse=1",
               name, c0, c1, c2, errs, period_pulse, e0, e1, e2);
    end else begin
      $display("period %s: on-counts %0d/%0d/%0d", name, c0, c1, c2);
    end
  endtask

  task automatic test_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = M_SOLID; cfg_duty = 4'd5;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (led_out !== 3'b000 || cfg_ready !== 1'b0 || cfg_err !== 1'b0 || period_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: led=%b ready=%b err=%b pulse=%b required 000/0/0/0",
               led_out, cfg_ready, cfg_err, period_pulse);
    end
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: cfg_ready=%b required 0 before first edge", cfg_ready);
    end
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: cfg_ready=%b required 1", cfg_ready);
    end
    $display("reset released, cfg_ready=%b", cfg_ready);
  endtask

  task automatic test_solid();
    cfg_write(2'd1, M_SOLID, 4'd5);
    wait_commit("solid");
    check_period("solid_p0", 0, 5, 0);
    check_period("solid_p1", 0, 5, 0);
  endtask

  task automatic test_handshake();
    logic saw_ready = 1'b0;
    while ((m_cyc % 16) != 5) @(negedge clk);
    cfg_write(2'd0, M_SOLID, 4'd9);
    // Second request held while ready is low must be ignored.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_mode = M_SOLID; cfg_duty = 4'd2;
    while ((m_cyc % 16) != 15) begin
      @(negedge clk);
      if (cfg_ready) saw_ready = 1'b1;
    end
    cfg_valid = 1'b0;
    checks++;
    if (saw_ready !== 1'b0) begin
      failures++;
      $display("FAIL handshake_ready_low: cfg_ready went %b mid-period, required 0", saw_ready);
    end
    wait_commit("handshake");
    check_period("handshake_p0", 9, 5, 0);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_no_second: cfg_ready=%b required 1", cfg_ready);
    end
    check_period("handshake_p1", 9, 5, 0);
  endtask

  task automatic test_bad_ch();
    cfg_write(2'd3, M_SOLID, 4'd7);
    wait_commit("bad_ch");
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_ch_err: cfg_err=%b required 1", cfg_err);
    end
    check_period("bad_ch_unchanged", 9, 5, 0);
  endtask

  task automatic test_accept_at_pend();
    while ((m_cyc % 16) != 15) @(negedge clk);
    cfg_write(2'd1, M_SOLID, 4'd12);
    check_period("pend_accept_deferred", 9, 5, 0);
    wait_commit("pend_accept");
    check_period("pend_accept_applied", 9, 12, 0);
  endtask

  task automatic test_blink();
    cfg_write(2'd0, M_BLINK, 4'd15);
    wait_commit("blink");
    for (int p = 0; p < 6; p++) begin
      int k = m_cyc / 16;
      int e0 = (((k / 2) % 2) != 0) ? 15 : 0;
      check_period("blink", e0, 12, 0);
    end
  endtask

  task automatic test_breathe();
    int exp_lv [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int c0, c1, c2, errs;
    cfg_write(2'd2, M_BREATHE, 4'd3);
    wait_commit("breathe");
    for (int p = 0; p < 8; p++) begin
      measure(c0, c1, c2, errs);
      checks++;
      if (c2 !== exp_lv[p] || c1 !== 12) begin
        failures++;
        $display("FAIL breathe_p%0d: ch2=%0d ch1=%0d required ch2=%0d ch1=12", p, c2, c1, exp_lv[p]);
      end else begin
        $display("breathe period %0d: ch2 on-count %0d", p, c2);
      end
    end
    // Level is now 2: first tick of the period drives ch2 high.
    @(negedge clk);
    checks++;
    if (led_out[2] !== 1'b1) begin
      failures++;
      $display("FAIL breathe_midramp: led2=%b required 1", led_out[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 3'b000 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: led=%b ready=%b required 000/0", led_out, cfg_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset2_ready: cfg_ready=%b required 1", cfg_ready);
    end
    while ((m_cyc % 16) != 0) @(negedge clk);
    check_period("after_reset", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_solid();
    test_handshake();
    test_bad_ch();
    test_accept_at_pend();
    test_blink();
    test_breathe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
